// File: rtl/clk_tick_gen_pkg.sv
// Shared types and default divisor constants for the clk_tick_gen clock-enable generator.
package clk_tick_gen_pkg;

  localparam int unsigned CNT_W_DEF = 16;
  localparam int unsigned MAX_NCH   = 8;
  localparam int unsigned CH_IDX_W  = 3;

  typedef logic [CNT_W_DEF-1:0] div_t;
  typedef logic [CH_IDX_W-1:0]  chan_idx_t;

  localparam int unsigned CLK_FREQ_HZ = 100_000_000;
  localparam int unsigned RAM_FREQ_HZ = 50_000_000;
  localparam int unsigned RTC_FREQ_HZ = 10_000_000;

  // (clk/target)/2 - 1, floored at zero so very fast targets still yield a legal divisor.
  function automatic div_t freq_to_div(int unsigned clk_hz, int unsigned tgt_hz);
    int unsigned half;
    half = (clk_hz / tgt_hz) / 2;
    return (half == 0) ? '0 : div_t'(half - 1);
  endfunction

  // Width of a channel-select field; a single channel still gets one bit.
  function automatic int unsigned ch_width(int unsigned nch);
    return (nch > 1) ? $clog2(nch) : 1;
  endfunction

  localparam div_t DIV_RAM = freq_to_div(CLK_FREQ_HZ, RAM_FREQ_HZ);
  localparam div_t DIV_RTC = freq_to_div(CLK_FREQ_HZ, RTC_FREQ_HZ);

  localparam logic [2*CNT_W_DEF-1:0] DIV_INIT_DEF = {DIV_RTC, DIV_RAM};

endpackage

// File: rtl/clk_tick_chan.sv
// One divider channel: counter, active/pending divisor, 1-cycle tick and 50% phase output.
// With CLK_TICK_GEN_SYNC_EN defined, the align input restarts the channel and applies pending state.
module clk_tick_chan
  import clk_tick_gen_pkg::*;
#(
  parameter int unsigned      CNT_W   = CNT_W_DEF,
  parameter logic [CNT_W-1:0] DIV_RST = '0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             en,
`ifdef CLK_TICK_GEN_SYNC_EN
  input  logic             align,
`endif
  input  logic             cfg_we,
  input  logic [CNT_W-1:0] cfg_div,
  output logic             tick,
  output logic             phase,
  output logic             busy
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] div_q, div_d;
  logic [CNT_W-1:0] pend_q, pend_d;
  logic             busy_q, busy_d;
  logic             tick_q, tick_d;
  logic             phase_q, phase_d;
  logic             at_term;
  logic [CNT_W-1:0] reload_div;
  logic             restart;

`ifdef CLK_TICK_GEN_SYNC_EN
  assign restart = align;
`else
  assign restart = 1'b0;
`endif

  // cnt never passes div because div only changes at a reload; >= is purely defensive.
  assign at_term = (cnt_q >= div_q);

  // A write is only accepted while nothing is pending, so the two sources never collide.
  assign reload_div = cfg_we ? cfg_div : (busy_q ? pend_q : div_q);

  always_comb begin
    cnt_d   = cnt_q;
    div_d   = div_q;
    pend_d  = pend_q;
    busy_d  = busy_q;
    tick_d  = 1'b0;
    phase_d = phase_q;
    if (restart || !en) begin
      cnt_d   = '0;
      phase_d = 1'b0;
      div_d   = reload_div;
      busy_d  = 1'b0;
    end else if (at_term) begin
      cnt_d   = '0;
      tick_d  = 1'b1;
      phase_d = ~phase_q;
      div_d   = reload_div;
      busy_d  = 1'b0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
      // Mid-period write is parked so the period in flight completes with the old divisor.
      if (cfg_we) begin
        pend_d = cfg_div;
        busy_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q   <= '0;
      div_q   <= DIV_RST;
      pend_q  <= '0;
      busy_q  <= 1'b0;
      tick_q  <= 1'b0;
      phase_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      div_q   <= div_d;
      pend_q  <= pend_d;
      busy_q  <= busy_d;
      tick_q  <= tick_d;
      phase_q <= phase_d;
    end
  end

  assign tick  = tick_q;
  assign phase = phase_q;
  assign busy  = busy_q;

endmodule

// File: rtl/clk_tick_gen.sv
// Multi-channel programmable clock-enable generator: NCH independent tick/phase dividers.
// Define CLK_TICK_GEN_SYNC_EN to add the sync input that realigns every channel at once.
module clk_tick_gen
  import clk_tick_gen_pkg::*;
#(
  parameter int unsigned              NCH      = 2,
  parameter int unsigned              CNT_W    = CNT_W_DEF,
  parameter logic [NCH*CNT_W-1:0]     DIV_INIT = DIV_INIT_DEF
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [NCH-1:0]           en,
  input  logic                     cfg_valid,
  output logic                     cfg_ready,
  input  logic [ch_width(NCH)-1:0] cfg_ch,
  input  logic [CNT_W-1:0]         cfg_div,
  output logic [NCH-1:0]           tick,
  output logic [NCH-1:0]           phase,
  output logic [NCH-1:0]           busy
`ifdef CLK_TICK_GEN_SYNC_EN
  ,
  input  logic                     sync
`endif
);

  chan_idx_t      cfg_idx;
  logic [NCH-1:0] cfg_we;

  assign cfg_idx = chan_idx_t'(cfg_ch);

  // Out-of-range channel numbers match nothing, so they read ready and are silently dropped.
  always_comb begin
    cfg_ready = 1'b1;
    for (int i = 0; i < int'(NCH); i++) begin
      if (cfg_idx == chan_idx_t'(i)) begin
        cfg_ready = ~busy[i];
      end
    end
`ifdef CLK_TICK_GEN_SYNC_EN
    if (sync) begin
      cfg_ready = 1'b0;
    end
`endif
  end

  for (genvar g = 0; g < NCH; g++) begin : g_chan
    assign cfg_we[g] = cfg_valid && cfg_ready && (cfg_idx == chan_idx_t'(g));

    clk_tick_chan #(
      .CNT_W   (CNT_W),
      .DIV_RST (DIV_INIT[g*CNT_W +: CNT_W])
    ) u_chan (
      .clock   (clock),
      .reset   (reset),
      .en      (en[g]),
`ifdef CLK_TICK_GEN_SYNC_EN
      .align   (sync),
`endif
      .cfg_we  (cfg_we[g]),
      .cfg_div (cfg_div),
      .tick    (tick[g]),
      .phase   (phase[g]),
      .busy    (busy[g])
    );
  end

endmodule

// File: tb/tb_clk_tick_gen.sv
// Self-checking bench for clk_tick_gen: period-countdown model compared every cycle plus
// hand-computed directed checks; the sync scenario is built when CLK_TICK_GEN_SYNC_EN is defined.
module tb_clk_tick_gen;

  localparam int NCH   = 2;
  localparam int CNT_W = 16;

  logic             clock = 1'b0;
  logic             reset = 1'b1;
  logic [NCH-1:0]   en = '0;
  logic             cfg_valid = 1'b0;
  logic             cfg_ready;
  logic             cfg_ch = 1'b0;
  logic [CNT_W-1:0] cfg_div = '0;
  logic [NCH-1:0]   tick, phase, busy;
  logic             sync = 1'b0;

  // Second instance with three channels so a 2-bit select can address a missing channel 3.
  logic [2:0]       en3 = 3'b111;
  logic             cfg_valid3 = 1'b0;
  logic             cfg_ready3;
  logic [1:0]       cfg_ch3 = 2'd0;
  logic [CNT_W-1:0] cfg_div3 = '0;
  logic [2:0]       tick3, phase3, busy3;

  int tests = 0;
  int fails = 0;

  always #5 clock = ~clock;

  clk_tick_gen #(
    .NCH      (NCH),
    .CNT_W    (CNT_W),
    .DIV_INIT ({16'd4, 16'd0})
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .en        (en),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_ch    (cfg_ch),
    .cfg_div   (cfg_div),
    .tick      (tick),
    .phase     (phase),
    .busy      (busy)
`ifdef CLK_TICK_GEN_SYNC_EN
    ,
    .sync      (sync)
`endif
  );

  clk_tick_gen #(
    .NCH      (3),
    .CNT_W    (CNT_W),
    .DIV_INIT ({16'd3, 16'd2, 16'd1})
  ) dut3 (
    .clock     (clock),
    .reset     (reset),
    .en        (en3),
    .cfg_valid (cfg_valid3),
    .cfg_ready (cfg_ready3),
    .cfg_ch    (cfg_ch3),
    .cfg_div   (cfg_div3),
    .tick      (tick3),
    .phase     (phase3),
    .busy      (busy3)
`ifdef CLK_TICK_GEN_SYNC_EN
    ,
    .sync      (1'b0)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Model: each channel tracks the period length (div+1) and the edges left until its tick.
  int m_per [NCH];
  int m_left[NCH];
  int m_pend[NCH];
  bit m_pv   [NCH];
  bit m_tick [NCH];
  bit m_phase[NCH];
  bit m_live = 1'b0;

  function automatic int reset_period(input int c);
    return (c == 0) ? 1 : 5;
  endfunction

  always @(posedge clock) begin : model
    bit acc;
    int nxt;
    for (int c = 0; c < NCH; c++) begin
      acc = cfg_valid && !sync && (int'(cfg_ch) == c) && !m_pv[c];
      nxt = acc ? int'(cfg_div) + 1 : (m_pv[c] ? m_pend[c] : m_per[c]);
      if (reset) begin
        m_per[c] = reset_period(c);
        m_left[c] = m_per[c];
        m_pv[c] = 1'b0;
        m_tick[c] = 1'b0;
        m_phase[c] = 1'b0;
      end else if (sync || !en[c]) begin
        m_per[c] = nxt;
        m_left[c] = nxt;
        m_pv[c] = 1'b0;
        m_tick[c] = 1'b0;
        m_phase[c] = 1'b0;
      end else begin
        m_left[c] = m_left[c] - 1;
        if (m_left[c] == 0) begin
          m_tick[c] = 1'b1;
          m_phase[c] = !m_phase[c];
          m_per[c] = nxt;
          m_left[c] = nxt;
          m_pv[c] = 1'b0;
        end else begin
          m_tick[c] = 1'b0;
          if (acc) begin
            m_pend[c] = int'(cfg_div) + 1;
            m_pv[c] = 1'b1;
          end
        end
      end
    end
    if (reset) m_live = 1'b1;
  end

  always @(negedge clock) begin : compare
    logic [NCH-1:0] et, ep, eb;
    logic           er;
    if (m_live) begin
      for (int c = 0; c < NCH; c++) begin
        et[c] = m_tick[c];
        ep[c] = m_phase[c];
        eb[c] = m_pv[c];
      end
      er = sync ? 1'b0 : !m_pv[int'(cfg_ch)];
      check("model tick", 32'(tick), 32'(et));
      check("model phase", 32'(phase), 32'(ep));
      check("model busy", 32'(busy), 32'(eb));
      check("model cfg_ready", 32'(cfg_ready), 32'(er));
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin : stim
    int n0, n1, n3a, n3b, n3c, first_both, first0;
    logic p1_mid;
    logic held;

    cyc(2);
    check("reset tick", 32'(tick), 32'h0);
    check("reset phase", 32'(phase), 32'h0);
    check("reset busy", 32'(busy), 32'h0);
    check("reset ready", 32'(cfg_ready), 32'h1);

    // Both channels free-run from their reset divisors (ch0 div 0, ch1 div 4).
    reset = 1'b0;
    en = 2'b11;
    n0 = 0; n1 = 0; p1_mid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      cyc(1);
      n0 += int'(tick[0]);
      n1 += int'(tick[1]);
      if (i == 4) p1_mid = phase[1];
    end
    check("ch0 ticks in 10", 32'(n0), 32'd10);
    check("ch1 ticks in 10", 32'(n1), 32'd2);
    check("ch1 phase after 1st tick", 32'(p1_mid), 32'h1);
    check("ch1 phase after 2nd tick", 32'(phase[1]), 32'h0);
    check("ch0 phase even", 32'(phase[0]), 32'h0);
    cyc(1);
    check("ch0 phase odd", 32'(phase[0]), 32'h1);
    cyc(1);

    // ch1 at cnt=2: write div 9, must wait for the current period to end.
    cfg_valid = 1'b1; cfg_ch = 1'b1; cfg_div = 16'd9;
    #1;
    check("ready before write", 32'(cfg_ready), 32'h1);
    cyc(1);
    cfg_valid = 1'b0;
    check("busy after mid write", 32'(busy), 32'h2);
    cfg_valid = 1'b1;
    #1;
    check("ready while busy", 32'(cfg_ready), 32'h0);
    cfg_valid = 1'b0;
    cyc(1);
    check("no early tick", 32'(tick[1]), 32'h0);
    cyc(1);
    check("old period tick", 32'(tick[1]), 32'h1);
    check("busy cleared at reload", 32'(busy[1]), 32'h0);
    n1 = 0;
    for (int i = 0; i < 10; i++) begin
      cyc(1);
      n1 += int'(tick[1]);
    end
    check("ch1 ticks in new period", 32'(n1), 32'd1);
    check("ch1 tick after 10", 32'(tick[1]), 32'h1);

    // Write exactly on the terminal-count edge: applies immediately, never busy.
    cyc(9);
    cfg_valid = 1'b1; cfg_ch = 1'b1; cfg_div = 16'd4;
    cyc(1);
    cfg_valid = 1'b0;
    check("tick on term write", 32'(tick[1]), 32'h1);
    check("no busy on term write", 32'(busy), 32'h0);
    n1 = 0;
    for (int i = 0; i < 5; i++) begin
      cyc(1);
      n1 += int'(tick[1]);
    end
    check("div4 ticks in 5", 32'(n1), 32'd1);
    check("div4 tick at 5", 32'(tick[1]), 32'h1);

    // Drop en[1] at cnt=3 with phase high, hold 7 cycles, then restart from zero.
    cyc(8);
    check("phase before drop", 32'(phase[1]), 32'h1);
    en = 2'b01;
    held = 1'b0;
    for (int i = 0; i < 7; i++) begin
      cyc(1);
      held |= tick[1] | phase[1];
    end
    check("disabled held low", 32'(held), 32'h0);
    en = 2'b11;
    n1 = 0;
    for (int i = 0; i < 4; i++) begin
      cyc(1);
      n1 += int'(tick[1]);
    end
    check("no partial period", 32'(n1), 32'd0);
    cyc(1);
    check("restart tick", 32'(tick[1]), 32'h1);

    // Make ch0 busy, then reset: divisor must return to its reset value.
    cfg_valid = 1'b1; cfg_ch = 1'b0; cfg_div = 16'd5;
    cyc(1);
    cfg_valid = 1'b0;
    check("ch0 term write no busy", 32'(busy[0]), 32'h0);
    cyc(1);
    cfg_valid = 1'b1; cfg_div = 16'd3;
    cyc(1);
    cfg_valid = 1'b0;
    check("ch0 busy", 32'(busy[0]), 32'h1);
    reset = 1'b1;
    cyc(1);
    check("reset clears busy", 32'(busy), 32'h0);
    check("reset clears tick", 32'(tick), 32'h0);
    check("reset clears phase", 32'(phase), 32'h0);
    reset = 1'b0;
    n0 = 0;
    for (int i = 0; i < 4; i++) begin
      cyc(1);
      n0 += int'(tick[0]);
    end
    check("ch0 div restored", 32'(n0), 32'd4);

    // Out-of-range channel on the 3-channel instance: accepted and dropped.
    cfg_valid3 = 1'b1; cfg_ch3 = 2'd3; cfg_div3 = 16'd7;
    #1;
    check("oor ready", 32'(cfg_ready3), 32'h1);
    cyc(1);
    cfg_valid3 = 1'b0;
    check("oor busy", 32'(busy3), 32'h0);
    n3a = 0; n3b = 0; n3c = 0;
    for (int i = 0; i < 12; i++) begin
      cyc(1);
      n3a += int'(tick3[0]);
      n3b += int'(tick3[1]);
      n3c += int'(tick3[2]);
    end
    check("oor ch0 ticks", 32'(n3a), 32'd6);
    check("oor ch1 ticks", 32'(n3b), 32'd4);
    check("oor ch2 ticks", 32'(n3c), 32'd3);

`ifdef CLK_TICK_GEN_SYNC_EN
    // Load div 2 / div 6 while disabled, start skewed, then realign with sync.
    en = 2'b00;
    cfg_valid = 1'b1; cfg_ch = 1'b0; cfg_div = 16'd2;
    cyc(1);
    cfg_ch = 1'b1; cfg_div = 16'd6;
    cyc(1);
    cfg_valid = 1'b0;
    en = 2'b01;
    cyc(2);
    en = 2'b11;
    cyc(2);
    cfg_valid = 1'b1; cfg_ch = 1'b1; cfg_div = 16'd6;
    cyc(1);
    cfg_valid = 1'b0;
    cyc(2);
    sync = 1'b1;
    #1;
    check("ready during sync", 32'(cfg_ready), 32'h0);
    cyc(1);
    sync = 1'b0;
    check("sync tick", 32'(tick), 32'h0);
    check("sync phase", 32'(phase), 32'h0);
    check("sync busy", 32'(busy), 32'h0);
    first_both = 0; first0 = 0;
    for (int i = 1; i <= 21; i++) begin
      cyc(1);
      if (tick[0] && first0 == 0) first0 = i;
      if (tick == 2'b11 && first_both == 0) first_both = i;
    end
    check("ch0 first tick after sync", 32'(first0), 32'd3);
    check("coincident tick after sync", 32'(first_both), 32'd21);
`endif

    cyc(2);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
